// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - RTYPE opcode and the mult/div/move-HI/LO funct codes
//   - FSM state encoding used by muldiv_unit
package muldiv_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative unsigned datapath, one step per 'step' cycle.
//   Multiply: shift-add; after WIDTH steps {acc,quo} is the 2*WIDTH product.
//   Divide (MULDIV_DIV_EN only): restoring; after WIDTH steps quo holds the
//   quotient and acc the remainder.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         latch a_in (multiplicand/dividend) and b_in (multiplier/divisor)
//   step         advance one iteration
//   div_mode     select restoring-divide step (present only with MULDIV_DIV_EN)
//   acc, quo     upper/lower working registers
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);

  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] quo_n;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
`endif

  // Multiplication is commutative, so quo always starts from a_in and the
  // divide path reuses the same register roles (quo = dividend, m = divisor).
  always_comb begin
    sum   = {1'b0, acc} + (quo[0] ? {1'b0, m} : '0);
    acc_n = sum[WIDTH:1];
    quo_n = {sum[0], quo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    sh   = {acc, quo[WIDTH-1]};
    // Only used when sh >= m, where the true difference fits in WIDTH bits.
    diff = sh[WIDTH-1:0] - m;
    if (div_mode) begin
      if (sh >= {1'b0, m}) begin
        acc_n = diff;
        quo_n = {quo[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = sh[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      quo <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= '0;
      quo <= a_in;
      m   <= b_in;
    end else if (step) begin
      acc <= acc_n;
      quo <= quo_n;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS mult/div unit with its own HI/LO registers.
//   Config macro: MULDIV_DIV_EN compiles in the divider; without it DIV/DIVU
//   are reported as illegal.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   instruction handshake (ready only in IDLE)
//   opcode, funct       instruction fields; only RTYPE is acted upon
//   rs_data, rt_data    operands (rs also MTHI/MTLO source)
//   flush               abort in-flight operation, block acceptance
//   busy                operation in flight
//   done                one-cycle pulse after HI/LO written by mult/div
//   illegal             one-cycle pulse for an unowned RTYPE funct
//   hi, lo              architectural HI/LO
//   mf_data             combinational MFHI/MFLO read port
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic             accept, is_mul, known, is_signed;
  logic             start_mul, start_div;
  logic             neg_q;
  logic [WIDTH-1:0] mag_rs, mag_rt, acc, quo;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MULDIV_DIV_EN
  logic             is_div_fn, neg_r, div0, is_div_op;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`endif

  assign accept = in_valid && in_ready && !flush && (opcode == OP_RTYPE);
  assign is_mul = (funct == F_MULT) || (funct == F_MULTU);

`ifdef MULDIV_DIV_EN
  assign is_div_fn = (funct == F_DIV) || (funct == F_DIVU);
  assign start_div = accept && is_div_fn;
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign known     = is_mul || is_div_fn || (funct == F_MTHI) || (funct == F_MTLO) ||
                     (funct == F_MFHI) || (funct == F_MFLO);
`else
  assign start_div = 1'b0;
  assign is_signed = (funct == F_MULT);
  assign known     = is_mul || (funct == F_MTHI) || (funct == F_MTLO) ||
                     (funct == F_MFHI) || (funct == F_MFLO);
`endif
  assign start_mul = accept && is_mul;

  assign mag_rs = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign mag_rt = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign mf_data  = (funct == F_MFHI) ? hi : lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_mul || start_div),
    .step     ((state == MUL) || (state == DIV)),
`ifdef MULDIV_DIV_EN
    .div_mode (state == DIV),
`endif
    .a_in     (mag_rs),
    .b_in     (mag_rt),
    .acc      (acc),
    .quo      (quo)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start_mul) state_n = MUL;
                else if (start_div) state_n = DIV;
      MUL, DIV: if (cnt == CW'(1)) state_n = FIX;
      FIX:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Sign fix-up applied in FIX. The divider leaves most-negative / -1 as
  // magnitude 2^(WIDTH-1) which negates back onto itself, so that case needs
  // no special handling; divide-by-zero only has to suppress quotient negation
  // (the restoring remainder already reconstructs rs_data).
  assign prod_fix = neg_q ? -{acc, quo} : {acc, quo};
`ifdef MULDIV_DIV_EN
  assign quo_fix  = (neg_q && !div0) ? -quo : quo;
  assign rem_fix  = neg_r ? -acc : acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      is_div_op <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      done    <= 1'b0;
      illegal <= accept && !known;

      if (start_mul || start_div) begin
        cnt   <= CW'(WIDTH);
        neg_q <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        neg_r     <= is_signed && rs_data[WIDTH-1];
        div0      <= (rt_data == '0);
        is_div_op <= start_div;
`endif
      end else if ((state == MUL) || (state == DIV)) begin
        cnt <= cnt - CW'(1);
      end

      if (accept && (funct == F_MTHI)) hi <= rs_data;
      if (accept && (funct == F_MTLO)) lo <= rs_data;

      if ((state == FIX) && !flush) begin
        done <= 1'b1;
`ifdef MULDIV_DIV_EN
        if (is_div_op) begin
          hi <= rem_fix;
          lo <= div0 ? '1 : quo_fix;
        end else
`endif
        begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [5:0]   opcode = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         in_ready, busy, done, illegal;
  logic [W-1:0] hi, lo, mf_data;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .funct    (funct),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .hi       (hi),
    .lo       (lo),
    .mf_data  (mf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called between edges; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    opcode   = op;
    funct    = fn;
    rs_data  = a;
    rt_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // cyc = k means done was seen in the cycle after edge E(k); 60 = timeout.
  task automatic wait_done(output int unsigned cyc, output bit ready_seen);
    cyc = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    while (!done && cyc < 60) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int unsigned cyc;
    bit rdy;
    @(negedge clk);
    issue(OP_RTYPE, fn, a, b);
    wait_done(cyc, rdy);
    check({tag, "_lat"}, cyc, W + 1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int unsigned cyc;
    bit rdy;
    bit seen;

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULTU max x max, with latency and in_ready behaviour
    @(negedge clk);
    issue(OP_RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", busy, 1);
    wait_done(cyc, rdy);
    check("multu_lat", cyc, W + 1);
    check("multu_ready_low", rdy, 0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_ready_done", in_ready, 1);
    @(negedge clk);
    check("multu_done_pulse", done, 0);

    // MULT -3 x 5, then next MULT accepted in the done cycle
    run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    check("b2b_ready", in_ready, 1);
    issue(OP_RTYPE, F_MULT, 32'd7, 32'hFFFF_FFFA);
    check("b2b_accept", busy, 1);
    wait_done(cyc, rdy);
    check("b2b_lat", cyc, W + 1);
    check("b2b_hi", hi, 32'hFFFF_FFFF);
    check("b2b_lo", lo, 32'hFFFF_FFD6);

    // MTHI / MFHI / MFLO
    @(negedge clk);
    issue(OP_RTYPE, F_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_busy", busy, 0);
    @(negedge clk);
    funct = F_MFHI;
    #1 check("mfhi", mf_data, 32'h0000_1234);
    funct = F_MFLO;
    #1 check("mflo", mf_data, 32'hFFFF_FFD6);

    // Unowned funct
    @(negedge clk);
    issue(OP_RTYPE, 6'h3F, 32'h5555_5555, 32'h1);
    @(negedge clk);
    check("ill_pulse", illegal, 1);
    check("ill_busy", busy, 0);
    check("ill_hi", hi, 32'h0000_1234);
    check("ill_lo", lo, 32'hFFFF_FFD6);
    @(negedge clk);
    check("ill_one_cycle", illegal, 0);

    // Non-RTYPE opcode with an MTLO funct is ignored
    issue(6'h08, F_MTLO, 32'hDEAD_BEEF, 32'd0);
    check("nonr_lo", lo, 32'hFFFF_FFD6);
    @(negedge clk);
    check("nonr_illegal", illegal, 0);

    // flush with in_valid in IDLE blocks acceptance
    flush = 1'b1;
    issue(OP_RTYPE, F_MULTU, 32'd3, 32'd3);
    flush = 1'b0;
    check("flush_idle_busy", busy, 0);

    // flush 10 cycles into a MULTU
    @(negedge clk);
    issue(OP_RTYPE, F_MULTU, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("flush_no_done", seen, 0);
    check("flush_hi", hi, 32'h0000_1234);
    check("flush_lo", lo, 32'hFFFF_FFD6);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("divu_gen", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    @(negedge clk);
    issue(OP_RTYPE, F_DIV, 32'd1000, 32'd3);
`else
    @(negedge clk);
    issue(OP_RTYPE, F_DIV, 32'hFFFF_FFF9, 32'd2);
    check("nodiv_busy", busy, 0);
    @(negedge clk);
    check("nodiv_illegal", illegal, 1);
    check("nodiv_hi", hi, 32'h0000_1234);
    check("nodiv_lo", lo, 32'hFFFF_FFD6);

    @(negedge clk);
    issue(OP_RTYPE, F_MULTU, 32'd1000, 32'd3);
`endif
    // Asynchronous reset mid-operation
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 1);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst", F_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
